// File: rtl/decode_bypass_stage.sv
// Decode stage between fetch and ALU: RF read, prioritised bypass resolution,
// load-use hazard detection and a registered valid/ready request toward the ALU.

package decode_bypass_pkg;
  localparam int INSTR_WIDTH = 32;
  localparam int PC_WIDTH    = 32;
  localparam int OPCODE_W    = 7;
  localparam int MEM_IMM_W   = 15;

  typedef enum logic [OPCODE_W-1:0] {
    OP_NOP  = 7'h00,
    OP_ADD  = 7'h01,
    OP_SUB  = 7'h02,
    OP_AND  = 7'h03,
    OP_OR   = 7'h04,
    OP_XOR  = 7'h05,
    OP_SLL  = 7'h06,
    OP_SRL  = 7'h07,
    OP_ADDI = 7'h08,
    OP_LDB  = 7'h10,
    OP_LDW  = 7'h11,
    OP_STB  = 7'h12,
    OP_STW  = 7'h13,
    OP_BEQ  = 7'h20,
    OP_JUMP = 7'h21
  } opcode_e;
endpackage

module decode_bypass_stage
  import decode_bypass_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_BYP = 3,
  parameter int OFF_W   = 32,
  parameter int CNT_W   = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [INSTR_WIDTH-1:0]      in_instr,
  input  logic [PC_WIDTH-1:0]         in_pc,
  output logic [REG_AW-1:0]           rf_rs1_addr,
  output logic [REG_AW-1:0]           rf_rs2_addr,
  input  logic [DATA_W-1:0]           rf_rs1_data,
  input  logic [DATA_W-1:0]           rf_rs2_data,
  input  logic [NUM_BYP-1:0]          byp_valid,
  input  logic [NUM_BYP*REG_AW-1:0]   byp_rd,
  input  logic [NUM_BYP-1:0]          byp_rdy,
  input  logic [NUM_BYP*DATA_W-1:0]   byp_data,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OPCODE_W-1:0]         out_opcode,
  output logic [REG_AW-1:0]           out_rd,
  output logic [REG_AW-1:0]           out_ra,
  output logic [DATA_W-1:0]           out_ra_data,
  output logic [DATA_W-1:0]           out_rb_data,
  output logic [OFF_W-1:0]            out_offset,
  output logic [PC_WIDTH-1:0]         out_pc,
  output logic                        out_xcpt_illegal,
  output logic [CNT_W-1:0]            stall_cnt
);

  // Instruction layout below the opcode: rd, ra, rb, then the low offset bits.
  localparam int RD_LSB    = INSTR_WIDTH - OPCODE_W - REG_AW;
  localparam int RA_LSB    = RD_LSB - REG_AW;
  localparam int RB_LSB    = RA_LSB - REG_AW;
  localparam int JMP_OFF_W = RD_LSB + REG_AW;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [REG_AW-1:0]   rd;
    logic [REG_AW-1:0]   ra;
    logic [DATA_W-1:0]   ra_data;
    logic [DATA_W-1:0]   rb_data;
    logic [OFF_W-1:0]    offset;
    logic [PC_WIDTH-1:0] pc;
    logic                illegal;
  } req_t;

  logic [OPCODE_W-1:0] opcode;
  logic [REG_AW-1:0]   rd_f;
  logic [REG_AW-1:0]   ra_f;
  logic [REG_AW-1:0]   rb_f;
  logic                use_src1;
  logic                use_src2;
  logic                is_store;
  logic                illegal;
  logic [OFF_W-1:0]    offset;

  logic                src1_hit;
  logic                src1_stall;
  logic [DATA_W-1:0]   src1_data;
  logic                src2_hit;
  logic                src2_stall;
  logic [DATA_W-1:0]   src2_data;

  logic                hazard;
  logic                load;

  logic                out_valid_q;
  logic                out_valid_d;
  req_t                req_q;
  req_t                req_d;
  logic [CNT_W-1:0]    stall_cnt_q;
  logic [CNT_W-1:0]    stall_cnt_d;

  assign opcode = in_instr[INSTR_WIDTH-1 -: OPCODE_W];
  assign rd_f   = in_instr[RD_LSB +: REG_AW];
  assign ra_f   = in_instr[RA_LSB +: REG_AW];
  assign rb_f   = in_instr[RB_LSB +: REG_AW];

  // Stores read their data register through the second port.
  assign rf_rs1_addr = ra_f;
  assign rf_rs2_addr = is_store ? rd_f : rb_f;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    use_src1 = 1'b0;
    use_src2 = 1'b0;
    is_store = 1'b0;
    illegal  = 1'b0;
    offset   = '0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL: begin
        use_src1 = 1'b1;
        use_src2 = 1'b1;
      end
      OP_ADDI: begin
        use_src1 = 1'b1;
        use_src2 = 1'b1;
        offset   = OFF_W'(in_instr[MEM_IMM_W-1:0]);
      end
      OP_LDB, OP_LDW: begin
        use_src1 = 1'b1;
        offset   = OFF_W'(in_instr[MEM_IMM_W-1:0]);
      end
      OP_STB, OP_STW: begin
        use_src1 = 1'b1;
        use_src2 = 1'b1;
        is_store = 1'b1;
        offset   = OFF_W'(in_instr[MEM_IMM_W-1:0]);
      end
      OP_BEQ: begin
        use_src1 = 1'b1;
        use_src2 = 1'b1;
        offset   = OFF_W'({rd_f, in_instr[RB_LSB-1:0]});
      end
      OP_JUMP: offset = OFF_W'(in_instr[JMP_OFF_W-1:0]);
      OP_NOP:  ;
      default: illegal = 1'b1;
    endcase
  end

  // Youngest matching bypass entry wins; older matches are shadowed.
  always_comb begin
    src1_hit   = 1'b0;
    src1_stall = 1'b0;
    src1_data  = rf_rs1_data;
    src2_hit   = 1'b0;
    src2_stall = 1'b0;
    src2_data  = rf_rs2_data;
    for (int i = 0; i < NUM_BYP; i++) begin
      if (!src1_hit && byp_valid[i] && (byp_rd[i*REG_AW +: REG_AW] == rf_rs1_addr)) begin
        src1_hit   = 1'b1;
        src1_stall = !byp_rdy[i];
        src1_data  = byp_data[i*DATA_W +: DATA_W];
      end
      if (!src2_hit && byp_valid[i] && (byp_rd[i*REG_AW +: REG_AW] == rf_rs2_addr)) begin
        src2_hit   = 1'b1;
        src2_stall = !byp_rdy[i];
        src2_data  = byp_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign hazard   = in_valid && !illegal &&
                    ((use_src1 && src1_stall) || (use_src2 && src2_stall));
  assign in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
  assign load     = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    req_d       = req_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (load) begin
      out_valid_d    = 1'b1;
      req_d.opcode   = opcode;
      req_d.rd       = rd_f;
      req_d.ra       = ra_f;
      req_d.ra_data  = src1_data;
      req_d.rb_data  = src2_data;
      req_d.offset   = offset;
      req_d.pc       = in_pc;
      req_d.illegal  = illegal;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hazard && !flush && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    if (reset) begin
      out_valid_q <= 1'b0;
      req_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      req_q       <= req_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid        = out_valid_q;
  assign out_opcode       = req_q.opcode;
  assign out_rd           = req_q.rd;
  assign out_ra           = req_q.ra;
  assign out_ra_data      = req_q.ra_data;
  assign out_rb_data      = req_q.rb_data;
  assign out_offset       = req_q.offset;
  assign out_pc           = req_q.pc;
  assign out_xcpt_illegal = req_q.illegal;
  assign stall_cnt        = stall_cnt_q;

endmodule
